muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer_pkg.sv | 49 ++++
 rtl/muldiv_step.sv | 50 +++++
 rtl/muldiv_sequencer.sv | 147 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared definitions for the iterative multiply/divide unit.
// Contents:
//   md_op_e     3-bit operation select driven by decode into muldiv_sequencer
//   md_state_e  sequencer FSM state encoding
//   FUNCT_*     MIPS SPECIAL funct codes that decode maps onto md_op_e
//   abs32       conditional two's-complement magnitude helper
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

   localparam int unsigned MD_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_RSV6  = 3'd6,
      OP_RSV7  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   // SPECIAL-opcode funct field values for the HI/LO instructions
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   // Magnitude of v when treated as signed (en=1); v unchanged otherwise.
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [MD_WIDTH-1:0] abs32(input logic [MD_WIDTH-1:0] v,
                                                 input logic                en);
      return (en && v[MD_WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the shift-add multiplier / restoring
// divider. The 64-bit accumulator is {hi,lo}.
// Ports:
//   i_acc      in  64  current {hi,lo}
//   i_operand  in  32  multiplicand (multiply) or divisor (divide), magnitude
//   i_div      in  1   1 = divide step, 0 = multiply step
//   o_acc      out 64  {hi,lo} after this iteration
// -----------------------------------------------------------------------------
module muldiv_step
   import muldiv_sequencer_pkg::*;
(
   input  logic [2*MD_WIDTH-1:0] i_acc,
   input  logic [MD_WIDTH-1:0]   i_operand,
   input  logic                  i_div,
   output logic [2*MD_WIDTH-1:0] o_acc
);

   logic [MD_WIDTH:0]   w_mul_sum;
   logic [MD_WIDTH:0]   w_rem_shift;
   logic                w_rem_ge;
   logic [MD_WIDTH-1:0] w_rem_diff;

   always_comb begin
      // Multiply: add multiplicand into upper half when the multiplier LSB is
      // set; the 33-bit sum keeps the carry, which shifts into hi[31].
      w_mul_sum   = {1'b0, i_acc[2*MD_WIDTH-1:MD_WIDTH]}
                  + (i_acc[0] ? {1'b0, i_operand} : {(MD_WIDTH+1){1'b0}});

      // Divide: shift {rem,quot} left by one, trial-subtract on 33 bits.
      // A non-negative trial always fits in 32 bits for a non-zero divisor;
      // with a zero divisor the low 32 bits simply keep shifting the dividend
      // in, which leaves the dividend magnitude in hi after 32 steps.
      w_rem_shift = {i_acc[2*MD_WIDTH-1:MD_WIDTH], i_acc[MD_WIDTH-1]};
      w_rem_ge    = (w_rem_shift >= {1'b0, i_operand});
      w_rem_diff  = w_rem_shift[MD_WIDTH-1:0] - i_operand;

      if (i_div) begin
         if (w_rem_ge) begin
            o_acc = {w_rem_diff, i_acc[MD_WIDTH-2:0], 1'b1};
         end else begin
            o_acc = {w_rem_shift[MD_WIDTH-1:0], i_acc[MD_WIDTH-2:0], 1'b0};
         end
      end else begin
         o_acc = {w_mul_sum, i_acc[MD_WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers. One
// iteration per cycle (32 RUN cycles), a FIX cycle for sign correction, then
// a DONE cycle in which the result is final and a new op may be accepted.
// Ports:
//   clk      in  1   rising-edge clock
//   rst_n    in  1   asynchronous active-low reset
//   start    in  1   execute stage holds a mul/div/move-to instruction
//   op       in  3   md_op_e operation select (6-7 ignored)
//   rs_val   in  32  multiplicand / dividend / MTHI-MTLO source
//   rt_val   in  32  multiplier / divisor
//   read_hi  in  1   execute stage holds MFHI
//   read_lo  in  1   execute stage holds MFLO
//   hi       out 32  HI register
//   lo       out 32  LO register
//   busy     out 1   operation in flight (RUN or FIX)
//   stall    out 1   hold IF/ID/EX this cycle
// -----------------------------------------------------------------------------
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [2:0]          op,
   input  logic [MD_WIDTH-1:0] rs_val,
   input  logic [MD_WIDTH-1:0] rt_val,
   input  logic                read_hi,
   input  logic                read_lo,
   output logic [MD_WIDTH-1:0] hi,
   output logic [MD_WIDTH-1:0] lo,
   output logic                busy,
   output logic                stall
);

   md_state_e           r_state;
   logic [4:0]          r_count;
   logic [MD_WIDTH-1:0] r_hi;
   logic [MD_WIDTH-1:0] r_lo;
   logic [MD_WIDTH-1:0] r_operand;
   logic                r_is_div;
   logic                r_neg_lo;   // negate product (mul) or quotient (div)
   logic                r_neg_hi;   // negate remainder (div only)
   logic                r_busy;

   md_op_e                w_op;
   logic                  w_signed;
   logic                  w_is_div;
   logic [MD_WIDTH-1:0]   w_rs_mag;
   logic [MD_WIDTH-1:0]   w_rt_mag;
   logic [2*MD_WIDTH-1:0] w_step_acc;
   logic [2*MD_WIDTH-1:0] w_neg_prod;

   assign w_op       = md_op_e'(op);
   assign w_signed   = ~op[0];     // MULT/DIV are the even encodings
   assign w_is_div   = op[1];
   assign w_rs_mag   = abs32(rs_val, w_signed);
   assign w_rt_mag   = abs32(rt_val, w_signed);
   assign w_neg_prod = ~{r_hi, r_lo} + 1'b1;

   muldiv_step u_step (
      .i_acc     ({r_hi, r_lo}),
      .i_operand (r_operand),
      .i_div     (r_is_div),
      .o_acc     (w_step_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_count   <= 5'd0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_operand <= '0;
         r_is_div  <= 1'b0;
         r_neg_lo  <= 1'b0;
         r_neg_hi  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            // DONE behaves like IDLE so a stalled start is taken immediately
            ST_IDLE, ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               if (start) begin
                  case (w_op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        r_hi      <= '0;
                        // divide: dividend in lo, divisor is the operand;
                        // multiply: multiplier in lo, multiplicand the operand
                        r_lo      <= w_is_div ? w_rs_mag : w_rt_mag;
                        r_operand <= w_is_div ? w_rt_mag : w_rs_mag;
                        r_is_div  <= w_is_div;
                        // a zero divisor must leave the all-ones quotient alone
                        r_neg_lo  <= w_signed & (rs_val[MD_WIDTH-1] ^ rt_val[MD_WIDTH-1])
                                     & (|rt_val);
                        r_neg_hi  <= w_signed & w_is_div & rs_val[MD_WIDTH-1];
                        r_count   <= 5'd31;
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                     end
                     OP_MTHI: r_hi <= rs_val;
                     OP_MTLO: r_lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               {r_hi, r_lo} <= w_step_acc;
               if (r_count == 5'd0) begin
                  r_state <= ST_FIX;
               end else begin
                  r_count <= r_count - 5'd1;
               end
            end
            ST_FIX: begin
               if (!r_is_div) begin
                  if (r_neg_lo) begin
                     {r_hi, r_lo} <= w_neg_prod;
                  end
               end else begin
                  if (r_neg_lo) begin
                     r_lo <= ~r_lo + 1'b1;
                  end
                  if (r_neg_hi) begin
                     r_hi <= ~r_hi + 1'b1;
                  end
               end
               r_state <= ST_DONE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign busy  = r_busy;
   // Combinational so decode sees the hold in the same cycle
   assign stall = r_busy & (read_hi | read_lo | start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed stimulus with a result scoreboard: issued mul/div operations push
// their hand-computed {hi,lo} into a queue, and a monitor pops and compares
// whenever busy falls (the DONE cycle). Timing, stall and move-to behaviour
// are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        read_hi;
   logic        read_lo;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   localparam logic [2:0] T_MULT  = 3'd0;
   localparam logic [2:0] T_MULTU = 3'd1;
   localparam logic [2:0] T_DIV   = 3'd2;
   localparam logic [2:0] T_DIVU  = 3'd3;
   localparam logic [2:0] T_MTHI  = 3'd4;
   localparam logic [2:0] T_MTLO  = 3'd5;
   localparam logic [2:0] T_RSV7  = 3'd7;

   typedef struct {
      string       name;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   skip_next = 1'b0;
   logic prev_busy = 1'b0;

   muldiv_sequencer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .read_hi (read_hi),
      .read_lo (read_lo),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .stall   (stall)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: a result is presented on the cycle busy drops.
   always @(negedge clk) begin
      exp_t e;
      if (prev_busy && !busy) begin
         if (skip_next) begin
            skip_next = 1'b0;
         end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got hi=%h lo=%h required no result", hi, lo);
         end else begin
            e = exp_q.pop_front();
            check32({e.name, "_hi"}, hi, e.exp_hi);
            check32({e.name, "_lo"}, lo, e.exp_lo);
            $display("result %-18s hi=%h lo=%h (expect hi=%h lo=%h)",
                     e.name, hi, lo, e.exp_hi, e.exp_lo);
         end
      end
      prev_busy = busy;
   end

   // Issue one op from idle; start is accepted at the edge after it is raised.
   // Returns 1 time unit after the accepting edge (cycle N+1).
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name, input logic [31:0] eh, input logic [31:0] el,
                        input bit push);
      @(posedge clk); #1;
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      if (push) exp_q.push_back('{name, eh, el});
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got busy=1 after %0d cycles required busy=0", name, n);
      end
   endtask

   // Hold an already-raised start until stall drops; returns the cycle index
   // (counted from first_k) at which it was taken.
   task automatic hold_until_taken(input int first_k, output int k);
      k = first_k;
      forever begin
         @(negedge clk);
         if (!stall || k > first_k + 100) break;
         k++;
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      int cnt;
      int k;

      rst_n = 1'b0; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
      read_hi = 1'b0; read_lo = 1'b0;

      // Reset state, with every stall source asserted
      repeat (2) @(negedge clk);
      start = 1'b1; read_hi = 1'b1; read_lo = 1'b1; #1;
      check32("reset_hi", hi, 32'h0);
      check32("reset_lo", lo, 32'h0);
      check32("reset_busy", 32'(busy), 32'd0);
      check32("reset_stall", 32'(stall), 32'd0);
      $display("reset hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, stall);
      start = 1'b0; read_hi = 1'b0; read_lo = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // MULTU max x max, and busy must last exactly 33 cycles
      issue(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 32'hFFFFFFFE, 32'h00000001, 1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      check32("multu_busy_cycles", cnt, 32'd33);
      $display("busy_cycles multu_max count=%0d", cnt);

      issue(T_MULT, 32'hFFFFFFF9, 32'd3, "mult_m7x3", 32'hFFFFFFFF, 32'hFFFFFFEB, 1);
      wait_idle("mult_m7x3");
      issue(T_DIV, 32'hFFFFFFF9, 32'd2, "div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
      wait_idle("div_m7d2");
      issue(T_DIVU, 32'd100, 32'd0, "divu_100d0", 32'd100, 32'hFFFFFFFF, 1);
      wait_idle("divu_100d0");
      issue(T_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min_dm1", 32'h0, 32'h80000000, 1);
      wait_idle("div_min_dm1");
      issue(T_DIV, 32'hFFFFFFFB, 32'd0, "div_m5d0", 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
      wait_idle("div_m5d0");

      // MFLO held from N+1: stall through N+33, final lo visible in N+34
      issue(T_DIVU, 32'd100, 32'd7, "divu_100d7", 32'd2, 32'd14, 1);
      read_lo = 1'b1;
      cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         checks++;
         if (stall !== (c <= 33)) begin
            errors++;
            cnt++;
            $display("FAIL stall_read_lo_c%0d: got %b required %b", c, stall, (c <= 33));
         end
         if (c == 34) check32("read_lo_value_at_done", lo, 32'd14);
      end
      read_lo = 1'b0;
      $display("stall_window read_lo bad_cycles=%0d", cnt);

      // Second start raised at N+5 while busy: taken in the DONE cycle N+34
      issue(T_MULT, 32'hFFFFFFF9, 32'd3, "mult_b2b_first", 32'hFFFFFFFF, 32'hFFFFFFEB, 1);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = T_DIV; rs_val = 32'hFFFFFFF9; rt_val = 32'd2;
      exp_q.push_back('{"div_b2b_second", 32'hFFFFFFFF, 32'hFFFFFFFD});
      hold_until_taken(5, k);
      check32("b2b_accept_cycle", k, 32'd34);
      $display("b2b second start accepted in cycle N+%0d", k);
      wait_idle("div_b2b_second");

      // MTLO while busy must stall and not disturb the in-flight product
      issue(T_MULTU, 32'd6, 32'd7, "multu_6x7", 32'd0, 32'd42, 1);
      start = 1'b1; op = T_MTLO; rs_val = 32'h00001234; rt_val = 32'h0;
      hold_until_taken(1, k);
      check32("mtlo_busy_accept_cycle", k, 32'd34);
      @(negedge clk);
      check32("mtlo_after_accept_lo", lo, 32'h00001234);
      check32("mtlo_after_accept_hi", hi, 32'h0);
      $display("mtlo during busy accepted cycle N+%0d lo=%h", k, lo);

      // MTHI from idle: one cycle, no busy
      @(posedge clk); #1;
      start = 1'b1; op = T_MTHI; rs_val = 32'hCAFEF00D;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check32("mthi_hi", hi, 32'hCAFEF00D);
      check32("mthi_lo_kept", lo, 32'h00001234);
      check32("mthi_busy", 32'(busy), 32'd0);
      $display("mthi hi=%h lo=%h busy=%b", hi, lo, busy);

      // Reserved op is ignored
      @(posedge clk); #1;
      start = 1'b1; op = T_RSV7; rs_val = 32'hDEADBEEF; rt_val = 32'h1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check32("rsv_hi_kept", hi, 32'hCAFEF00D);
      check32("rsv_lo_kept", lo, 32'h00001234);
      check32("rsv_busy", 32'(busy), 32'd0);
      $display("reserved op hi=%h lo=%h busy=%b", hi, lo, busy);

      // Reset mid-DIV at N+10 aborts asynchronously
      issue(T_DIV, 32'd1000, 32'd3, "div_aborted", 32'h0, 32'h0, 0);
      repeat (9) @(posedge clk);
      #2;
      skip_next = 1'b1;
      read_lo = 1'b1;
      rst_n = 1'b0;
      #1;
      check32("abort_hi", hi, 32'h0);
      check32("abort_lo", lo, 32'h0);
      check32("abort_busy", 32'(busy), 32'd0);
      check32("abort_stall", 32'(stall), 32'd0);
      $display("mid-op reset hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, stall);
      read_lo = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      issue(T_MULTU, 32'd6, 32'd7, "multu_after_reset", 32'd0, 32'd42, 1);
      wait_idle("multu_after_reset");

      @(negedge clk);
      check32("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
